brch_tag_ctrl: RTL

- Allocates, tracks and retires branch checkpoint tags for up to 4 decoded branches per cycle.
- Sequences the pipeline flush on a misprediction.
- Sits between decode/rename, the ROB commit port and the branch resolution port.
- Holds outstanding branches in an in-order circular queue. It stalls decode when no tags are free and drives the flush position/mask plus the NOP-injection request.

---
 rtl/brch_tag_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/brch_tag_ctrl.sv
// brch_tag_ctrl: allocates/retires branch checkpoint tags in an in-order ring and sequences mispredict flushes.
// Define BRCH_TAG_CHK_EN to build the sticky tag_err index checker.
module brch_tag_ctrl #(
  parameter int NUM_TAGS   = 4,
  parameter int TAG_W      = 2,
  parameter int IDX_W      = 6,
  parameter int POS_W      = 7,
  parameter int FLUSH_HOLD = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_vld,
  input  logic [3:0]          dec_brch,
  input  logic [IDX_W-1:0]    dec_indx,
  input  logic [4*POS_W-1:0]  dec_pos,
  output logic [4*TAG_W-1:0]  alloc_tag,
  output logic                stall_dec,
  input  logic                cmt_brch,
  input  logic [IDX_W-1:0]    cmt_brch_indx,
  input  logic                mis_pred,
  input  logic [IDX_W-1:0]    brch_mis_indx,
  input  logic                flush_ack,
  output logic                flush,
  output logic [POS_W-1:0]    flush_pos,
  output logic [NUM_TAGS-1:0] flush_mask,
  output logic                all_nop,
  output logic [TAG_W:0]      free_cnt,
  output logic                tag_err
);
  localparam int CNT_W = TAG_W + 1;
  localparam int CW = TAG_W + 2;
  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;
  state_t r_state, w_state_nx;
  logic [NUM_TAGS-1:0] r_vld;
  logic [IDX_W-1:0] r_indx [NUM_TAGS];
  logic [POS_W-1:0] r_pos [NUM_TAGS];
  logic [TAG_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count, r_free;
  logic [POS_W-1:0] r_flush_pos;
  logic [NUM_TAGS-1:0] r_flush_mask;
  logic [2:0] r_hold;
  logic w_idle, w_pop, w_mis, w_hit, w_fit, w_alloc, w_ack;
  logic [2:0] w_n;
  logic [TAG_W-1:0] w_e;
  logic [NUM_TAGS-1:0] w_kill, w_vld_pop;
  logic [CNT_W-1:0] w_kcnt, w_count_nx;
  logic [CW-1:0] w_room;
  // Lane tags are tail plus the number of older branch lanes in the group.
  always_comb begin
    w_n = 3'd0;
    alloc_tag = '0;
    for (int k = 0; k < 4; k++) begin
      if (dec_brch[k]) alloc_tag[k*TAG_W +: TAG_W] = r_tail + w_n[TAG_W-1:0];
      w_n = w_n + {2'b0, dec_brch[k]};
    end
    if (!dec_vld) w_n = 3'd0;
  end
  assign w_idle = r_state == IDLE;
  assign w_pop = cmt_brch && r_vld[r_head] && cmt_brch_indx == r_indx[r_head];
  assign w_room = CW'(NUM_TAGS) - CW'(r_count) + CW'(w_pop);
  assign w_fit = CW'(w_n) <= w_room;
  assign w_mis = w_idle && mis_pred;
  assign w_alloc = w_idle && !mis_pred && dec_vld && w_fit;
  assign w_ack = r_state == FLUSH && flush_ack;
  assign stall_dec = (dec_vld && !w_fit) || mis_pred || !w_idle;
  assign all_nop = w_mis || !w_idle;
  assign flush = r_state == FLUSH;
  assign flush_pos = r_flush_pos;
  assign flush_mask = r_flush_mask;
  assign free_cnt = r_free;
  // Search sees the queue after this cycle's commit; oldest match wins.
  always_comb begin
    w_vld_pop = r_vld;
    if (w_pop) w_vld_pop[r_head] = 1'b0;
    w_hit = 1'b0;
    w_e = '0;
    for (int k = NUM_TAGS - 1; k >= 0; k--)
      if (w_vld_pop[r_head + TAG_W'(k)] && r_indx[r_head + TAG_W'(k)] == brch_mis_indx) begin
        w_hit = 1'b1;
        w_e = r_head + TAG_W'(k);
      end
    w_kill = '0;
    w_kcnt = '0;
    for (int k = 0; k < NUM_TAGS; k++)
      if (w_hit && w_vld_pop[k] && (TAG_W'(k) - r_head) > (w_e - r_head)) begin
        w_kill[k] = 1'b1;
        w_kcnt = w_kcnt + CNT_W'(1);
      end
    w_count_nx = r_count - CNT_W'(w_pop);
    if (w_alloc) w_count_nx = w_count_nx + CNT_W'(w_n);
    if (w_mis) w_count_nx = w_count_nx - w_kcnt;
  end
  always_comb
    w_state_nx = w_mis ? FLUSH : w_ack ? DRAIN : (r_state == DRAIN && r_hold == 3'd0) ? IDLE : r_state;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_vld <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_free <= CNT_W'(NUM_TAGS);
      r_flush_pos <= '0;
      r_flush_mask <= '0;
      r_hold <= '0;
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
      r_free <= CNT_W'(NUM_TAGS) - w_count_nx;
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head <= r_head + TAG_W'(1);
      end
      if (w_mis) begin
        r_vld <= w_vld_pop & ~w_kill;
        r_tail <= w_hit ? w_e + TAG_W'(1) : r_tail;
        r_flush_pos <= w_hit ? r_pos[w_e] : dec_pos[POS_W-1:0];
        r_flush_mask <= w_kill;
      end
      if (w_alloc) begin
        for (int k = 0; k < 4; k++)
          if (dec_brch[k]) begin
            r_vld[alloc_tag[k*TAG_W +: TAG_W]] <= 1'b1;
            r_indx[alloc_tag[k*TAG_W +: TAG_W]] <= dec_indx + IDX_W'(k);
            r_pos[alloc_tag[k*TAG_W +: TAG_W]] <= dec_pos[k*POS_W +: POS_W];
          end
        r_tail <= r_tail + w_n[TAG_W-1:0];
      end
      if (w_ack) begin
        r_flush_mask <= '0;
        r_hold <= 3'(FLUSH_HOLD - 1);
      end else if (r_state == DRAIN && r_hold != 3'd0) r_hold <= r_hold - 3'd1;
    end
  end
`ifdef BRCH_TAG_CHK_EN
  logic r_tag_err;
  always_ff @(posedge clk) begin
    if (rst) r_tag_err <= 1'b0;
    else if ((cmt_brch && !w_pop) || (w_mis && !w_hit)) r_tag_err <= 1'b1;
  end
  assign tag_err = r_tag_err;
`else
  assign tag_err = 1'b0;
`endif
endmodule
